// File: rtl/fsbm_ctr_seq.sv
// Control sequencer for the full-search block-matching PE array: preload, 2P+1 scan lines, done.
// Optional abort input enabled by defining FSBM_CTR_ABORT_EN.
module fsbm_ctr_seq #(
  parameter int BLOCK_N     = 16,
  parameter int SEARCH_P    = 4,
  parameter int CTR_WIDTH   = 4,
  parameter int WORD_WIDETH = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic                                 turnenable,
`ifdef FSBM_CTR_ABORT_EN
  input  logic                                 abort,
`endif
  output logic [CTR_WIDTH-1:0]                 ctr_word,
  output logic                                 mem_en_input,
  output logic                                 mem_init_mode,
  output logic                                 sad_valid,
  output logic [$clog2(2*SEARCH_P+1)-1:0]      vpos,
  output logic                                 busy,
  output logic                                 done
);

  localparam int LINE_LEN  = BLOCK_N + 2*SEARCH_P;
  localparam int NUM_LINES = 2*SEARCH_P + 1;
  localparam int CW        = $clog2(LINE_LEN);
  localparam int VW        = $clog2(NUM_LINES);

  localparam logic [CW-1:0] C_INIT_LAST = CW'(BLOCK_N - 1);
  localparam logic [CW-1:0] C_LINE_LAST = CW'(LINE_LEN - 1);
  localparam logic [VW-1:0] V_LAST      = VW'(2*SEARCH_P);

  // Word width only matters to the array; it is checked here so a bad configuration fails early.
  if (WORD_WIDETH < 1 || BLOCK_N < 2 || SEARCH_P < 1 || (1 << CTR_WIDTH) < NUM_LINES) begin : g_bad_cfg
    $error("fsbm_ctr_seq: invalid parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state, state_n;
  logic [CW-1:0]        c, c_n;
  logic [VW-1:0]        vpos_n;
  logic [CTR_WIDTH-1:0] word_n;
  logic                 in_run, sad_n, abort_req;

`ifdef FSBM_CTR_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  always_comb begin
    state_n = state;
    c_n     = c;
    vpos_n  = vpos;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = INIT;
          c_n     = '0;
          vpos_n  = '0;
        end
      end
      INIT: begin
        if (abort_req) begin
          state_n = IDLE;
          c_n     = '0;
          vpos_n  = '0;
        end else if (turnenable) begin
          if (c == C_INIT_LAST) begin
            state_n = SCAN;
            c_n     = '0;
            vpos_n  = '0;
          end else begin
            c_n = c + 1'b1;
          end
        end
      end
      SCAN: begin
        if (abort_req) begin
          state_n = IDLE;
          c_n     = '0;
          vpos_n  = '0;
        end else if (turnenable) begin
          if (c == C_LINE_LAST) begin
            c_n = '0;
            if (vpos == V_LAST) begin
              state_n = DONE;
              vpos_n  = '0;
            end else begin
              vpos_n = vpos + 1'b1;
            end
          end else begin
            c_n = c + 1'b1;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
        c_n     = '0;
        vpos_n  = '0;
      end
      default: begin
        state_n = IDLE;
        c_n     = '0;
        vpos_n  = '0;
      end
    endcase

    // Outputs are decoded from the next state so they are valid in the cycle that state begins.
    in_run = (state_n == INIT) || (state_n == SCAN);
    sad_n  = (state_n == SCAN) && turnenable && (c_n >= C_INIT_LAST);
    word_n = ctr_word;
    if (sad_n) begin
      word_n = CTR_WIDTH'(c_n - C_INIT_LAST);
    end else if (!in_run) begin
      word_n = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      c             <= '0;
      vpos          <= '0;
      ctr_word      <= '0;
      mem_en_input  <= 1'b0;
      mem_init_mode <= 1'b0;
      sad_valid     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_n;
      c             <= c_n;
      vpos          <= (state_n == SCAN) ? vpos_n : '0;
      ctr_word      <= word_n;
      mem_en_input  <= in_run && turnenable;
      mem_init_mode <= (state_n == INIT);
      sad_valid     <= sad_n;
      busy          <= in_run;
      done          <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_fsbm_ctr_seq.sv
// Scoreboard bench for fsbm_ctr_seq: default (16,4) and small (8,2) instances behind one observation mux.
// Abort scenario is built only when FSBM_CTR_ABORT_EN is defined.
module tb_fsbm_ctr_seq;

  typedef struct {
    int cyc;
    int ctr;
    int vp;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic turnenable;
  logic sel;
  logic start_big, start_sm;
`ifdef FSBM_CTR_ABORT_EN
  logic abort;
  logic abort_big, abort_sm;
`endif

  logic [3:0] big_ctr, big_vpos;
  logic       big_en, big_init, big_sad, big_busy, big_done;
  logic [2:0] sm_ctr, sm_vpos;
  logic       sm_en, sm_init, sm_sad, sm_busy, sm_done;

  logic [3:0] obs_ctr, obs_vpos;
  logic       obs_en, obs_init, obs_sad, obs_busy, obs_done;

  int   compared = 0;
  int   failed   = 0;
  int   pe       = 0;
  int   base     = 0;
  int   curN, curP, curL;
  exp_t sadQ[$];
  int   doneQ[$];

  always #5 clk = ~clk;
  always @(posedge clk) pe <= pe + 1;

  assign start_big = start & ~sel;
  assign start_sm  = start & sel;
`ifdef FSBM_CTR_ABORT_EN
  assign abort_big = abort & ~sel;
  assign abort_sm  = abort & sel;
`endif

  fsbm_ctr_seq #(.BLOCK_N(16), .SEARCH_P(4), .CTR_WIDTH(4), .WORD_WIDETH(8)) dut_big (
    .clk(clk),
    .rst_n(rst_n),
    .start(start_big),
    .turnenable(turnenable),
`ifdef FSBM_CTR_ABORT_EN
    .abort(abort_big),
`endif
    .ctr_word(big_ctr),
    .mem_en_input(big_en),
    .mem_init_mode(big_init),
    .sad_valid(big_sad),
    .vpos(big_vpos),
    .busy(big_busy),
    .done(big_done)
  );

  fsbm_ctr_seq #(.BLOCK_N(8), .SEARCH_P(2), .CTR_WIDTH(3), .WORD_WIDETH(8)) dut_sm (
    .clk(clk),
    .rst_n(rst_n),
    .start(start_sm),
    .turnenable(turnenable),
`ifdef FSBM_CTR_ABORT_EN
    .abort(abort_sm),
`endif
    .ctr_word(sm_ctr),
    .mem_en_input(sm_en),
    .mem_init_mode(sm_init),
    .sad_valid(sm_sad),
    .vpos(sm_vpos),
    .busy(sm_busy),
    .done(sm_done)
  );

  always_comb begin
    if (sel) begin
      obs_ctr  = {1'b0, sm_ctr};
      obs_vpos = {1'b0, sm_vpos};
      obs_en   = sm_en;
      obs_init = sm_init;
      obs_sad  = sm_sad;
      obs_busy = sm_busy;
      obs_done = sm_done;
    end else begin
      obs_ctr  = big_ctr;
      obs_vpos = big_vpos;
      obs_en   = big_en;
      obs_init = big_init;
      obs_sad  = big_sad;
      obs_busy = big_busy;
      obs_done = big_done;
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected sad_valid beats: line v, candidate k appears at cycle 2N + v*L + k, shifted by any stall.
  function automatic void pushExpected(input int stallAt, input int cutAt);
    exp_t e;
    for (int v = 0; v <= 2*curP; v++) begin
      for (int k = 0; k <= 2*curP; k++) begin
        e.cyc = 2*curN + v*curL + k;
        if (stallAt > 0 && e.cyc > stallAt) e.cyc += 3;
        e.ctr = k;
        e.vp  = v;
        if (cutAt == 0 || e.cyc <= cutAt) sadQ.push_back(e);
      end
    end
    if (cutAt == 0) doneQ.push_back(curN + 1 + (2*curP + 1)*curL + ((stallAt > 0) ? 3 : 0));
  endfunction

  // Monitor: pops an expectation whenever the DUT presents sad_valid or done.
  always @(negedge clk) begin
    exp_t e;
    int   rel;
    rel = pe - base + 1;
    if (obs_sad) begin
      if (sadQ.size() == 0) begin
        checkOutput("sad_unexpected", int'(obs_sad), 0);
      end else begin
        e = sadQ.pop_front();
        checkOutput("sad_cycle", rel, e.cyc);
        checkOutput("sad_ctr_word", int'(obs_ctr), e.ctr);
        checkOutput("sad_vpos", int'(obs_vpos), e.vp);
      end
    end
    if (obs_done) begin
      if (doneQ.size() == 0) begin
        checkOutput("done_unexpected", int'(obs_done), 0);
      end else begin
        checkOutput("done_cycle", rel, doneQ.pop_front());
        checkOutput("done_busy", int'(obs_busy), 0);
      end
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctr_word"}, int'(obs_ctr), 0);
    checkOutput({tag, "_mem_en"}, int'(obs_en), 0);
    checkOutput({tag, "_init_mode"}, int'(obs_init), 0);
    checkOutput({tag, "_sad_valid"}, int'(obs_sad), 0);
    checkOutput({tag, "_vpos"}, int'(obs_vpos), 0);
    checkOutput({tag, "_busy"}, int'(obs_busy), 0);
    checkOutput({tag, "_done"}, int'(obs_done), 0);
  endtask

  // Called at a negedge with the selected DUT idle. cutMode: 0 none, 1 abort, 2 reset at cycle cutAt.
  task automatic applyStimulus(input int stallAt, input bit repulse, input int cutMode, input int cutAt);
    int doneCyc, last;
    bit expInit, expBusy, expEn, stallCyc, cut;
    doneCyc = curN + 1 + (2*curP + 1)*curL + ((stallAt > 0) ? 3 : 0);
    last    = (cutMode == 1) ? cutAt + 10 : ((cutMode == 2) ? cutAt : doneCyc);
    pushExpected(stallAt, (cutMode != 0) ? cutAt : 0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    base  = pe;
    for (int rel = 1; rel <= last; rel++) begin
      @(negedge clk);
      cut      = (cutMode != 0) && (rel > cutAt);
      stallCyc = (stallAt > 0) && (rel > stallAt) && (rel <= stallAt + 3);
      expInit  = (rel <= curN) && !cut;
      expBusy  = (rel < doneCyc) && !cut;
      expEn    = expBusy && !stallCyc;
      checkOutput("init_mode", int'(obs_init), int'(expInit));
      checkOutput("busy", int'(obs_busy), int'(expBusy));
      checkOutput("mem_en_input", int'(obs_en), int'(expEn));
      if (stallCyc) begin
        checkOutput("stall_sad_valid", int'(obs_sad), 0);
        checkOutput("stall_ctr_word", int'(obs_ctr), stallAt - 2*curN - 2*curL);
        checkOutput("stall_vpos", int'(obs_vpos), 2);
      end
      if (stallAt > 0 && rel == stallAt) turnenable = 1'b0;
      if (stallAt > 0 && rel == stallAt + 3) turnenable = 1'b1;
      if (repulse) begin
        if (rel == 5 || rel == doneCyc) start = 1'b1;
        if (rel == 6) start = 1'b0;
      end
`ifdef FSBM_CTR_ABORT_EN
      if (cutMode == 1 && rel == cutAt) abort = 1'b1;
      if (cutMode == 1 && rel == cutAt + 1) abort = 1'b0;
`endif
      if (cutMode == 2 && rel == cutAt) begin
        checkOutput("vpos_before_reset", int'(obs_vpos), (cutAt - 2*curN) / curL);
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("async_reset");
        sadQ.delete();
        doneQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          checkOutput("post_reset_busy", int'(obs_busy), 0);
        end
        break;
      end
    end
    #2;
    checkOutput("sad_missing", sadQ.size(), 0);
    checkOutput("done_missing", doneQ.size(), 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    turnenable = 1'b1;
    sel        = 1'b0;
`ifdef FSBM_CTR_ABORT_EN
    abort      = 1'b0;
`endif
    curN = 16;
    curP = 4;
    curL = 24;
    #1;
    checkAllZero("reset");
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] default search, no stall");
    applyStimulus(0, 1'b0, 0, 0);
    @(negedge clk);

    $display("[TB] default search, 3-cycle stall in line 2");
    applyStimulus(83, 1'b0, 0, 0);
    @(negedge clk);

    $display("[TB] start re-pulsed in INIT and DONE, then restart right after DONE");
    applyStimulus(0, 1'b1, 0, 0);
    @(negedge clk);
    checkOutput("after_done_busy", int'(obs_busy), 0);
    checkOutput("after_done_init", int'(obs_init), 0);
    applyStimulus(0, 1'b0, 0, 0);
    @(negedge clk);

    $display("[TB] reset asserted mid-scan at vpos 4");
    applyStimulus(0, 1'b0, 2, 130);
    @(negedge clk);

    $display("[TB] small configuration N=8 P=2");
    sel  = 1'b1;
    curN = 8;
    curP = 2;
    curL = 12;
    @(negedge clk);
    applyStimulus(0, 1'b0, 0, 0);
    @(negedge clk);
    sel  = 1'b0;
    curN = 16;
    curP = 4;
    curL = 24;
    @(negedge clk);

`ifdef FSBM_CTR_ABORT_EN
    $display("[TB] abort at cycle 50, then fresh search");
    applyStimulus(0, 1'b0, 1, 50);
    @(negedge clk);
    applyStimulus(0, 1'b0, 0, 0);
    @(negedge clk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
